weight_load_ctrl: RTL and testbench

Sequencer between the Weight FIFO and the 8x8 PE array. On a load request it pops one full weight tile (NUM_PE_ROWS x MATRIX_SIZE weights) from the Weight FIFO, then streams it into the array one PE row per cycle. It completes with a one-cycle done pulse and keeps a running count of loaded tiles. It queues one request while busy and never reads an empty FIFO.

---
 rtl/weight_load_ctrl_if.sv | 35 +++
 rtl/weight_load_ctrl.sv | 108 ++++++++++
 tb/tb_weight_load_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_load_ctrl_if.sv
// rtl/weight_load_ctrl_if.sv - Weight FIFO read port and PE-array row stream bundle
interface weight_load_ctrl_if #(
    parameter int WEIGHT_BW   = 8,
    parameter int NUM_PE_ROWS = 8,
    parameter int MATRIX_SIZE = 8
);
    localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
    localparam int TILE_W = ROW_W * NUM_PE_ROWS;
    localparam int IDX_W  = $clog2(NUM_PE_ROWS);

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [TILE_W-1:0] fifo_data;
    logic              row_valid;
    logic [IDX_W-1:0]  row_idx;
    logic [ROW_W-1:0]  row_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output row_valid,
        output row_idx,
        output row_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  row_valid,
        input  row_idx,
        input  row_data
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - pops one weight tile from the Weight FIFO and streams it row by row into the PE array
module weight_load_ctrl #(
    parameter int WEIGHT_BW   = 8,
    parameter int NUM_PE_ROWS = 8,
    parameter int MATRIX_SIZE = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    weight_load_ctrl_if.master  bus,
    output logic                load_done,
    output logic                busy,
    output logic [15:0]         tile_count
);
    localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE;
    localparam int IDX_W = $clog2(NUM_PE_ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        LOAD,
        DONE
    } state_t;

    state_t                             state;
    logic                               pend;
    logic [IDX_W-1:0]                   ridx;
    logic [NUM_PE_ROWS-1:0][ROW_W-1:0]  tile_reg;
    logic                               rd_en_q;
    logic                               row_valid_q;
    logic                               load_done_q;

    // Sequencer: request intake, FIFO pop, row streaming (highest row first) and completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pend        <= 1'b0;
            ridx        <= '0;
            tile_reg    <= '0;
            rd_en_q     <= 1'b0;
            row_valid_q <= 1'b0;
            load_done_q <= 1'b0;
            tile_count  <= 16'd0;
        end else if (abort) begin
            // Abort drops any popped tile and any queued request; start on this edge is lost too
            state       <= IDLE;
            pend        <= 1'b0;
            ridx        <= '0;
            rd_en_q     <= 1'b0;
            row_valid_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || pend) begin
                        if (!bus.fifo_empty) begin
                            pend    <= 1'b0;
                            rd_en_q <= 1'b1;
                            state   <= READ;
                        end else begin
                            // Hold the request until the FIFO has a tile; never pop an empty FIFO
                            pend <= 1'b1;
                        end
                    end
                end
                READ: begin
                    rd_en_q <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    tile_reg    <= bus.fifo_data;
                    ridx        <= LAST_ROW;
                    row_valid_q <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    if (ridx == '0) begin
                        row_valid_q <= 1'b0;
                        load_done_q <= 1'b1;
                        tile_count  <= tile_count + 16'd1;
                        state       <= DONE;
                    end else begin
                        ridx <= ridx - IDX_W'(1);
                    end
                end
                DONE: begin
                    load_done_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // One request may be queued while a load is in flight, including on the DONE exit edge
            if (state != IDLE && start) begin
                pend <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.row_valid  = row_valid_q;
    assign bus.row_idx    = ridx;
    assign bus.row_data   = tile_reg[ridx];
    assign load_done      = load_done_q;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - self-checking bench for weight_load_ctrl
module tb_weight_load_ctrl;
    localparam int WBW    = 8;
    localparam int NR     = 8;
    localparam int MS     = 8;
    localparam int ROW_W  = WBW * MS;
    localparam int TILE_W = ROW_W * NR;

    typedef struct {
        logic       start;
        logic       abort;
        logic       exp_rd;
        logic       exp_rv;
        logic [2:0] exp_idx;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        load_done;
    logic        busy;
    logic [15:0] tile_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [TILE_W-1:0] fifo_q[$];
    logic [TILE_W-1:0] sb_q[$];
    int                done_q[$];
    int                row_start_q[$];

    logic [NR-1:0][ROW_W-1:0] inflight;
    bit                       inflight_valid = 1'b0;
    logic [2:0]               exp_ridx = 3'd0;
    int                       rows_seen = 0;
    int                       exp_count = 0;
    bit                       prev_rd = 1'b0;

    vec_t tbl[12];

    weight_load_ctrl_if #(.WEIGHT_BW(WBW), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS)) wl_if ();

    weight_load_ctrl #(.WEIGHT_BW(WBW), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .bus        (wl_if),
        .load_done  (load_done),
        .busy       (busy),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight FIFO model: data appears the cycle after the rd_en cycle
    assign wl_if.fifo_empty = (fifo_q.size() == 0);
    always @(posedge clk) begin
        if (wl_if.fifo_rd_en && fifo_q.size() != 0) wl_if.fifo_data <= fifo_q.pop_front();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [ROW_W-1:0] pat_row(input int r);
        logic [ROW_W-1:0] v;
        for (int c = 0; c < MS; c++) v[c*8 +: 8] = 8'(r * 8 + c);
        return v;
    endfunction

    function automatic logic [TILE_W-1:0] pat_tile();
        logic [TILE_W-1:0] t;
        for (int r = 0; r < NR; r++) t[r*ROW_W +: ROW_W] = pat_row(r);
        return t;
    endfunction

    function automatic logic [TILE_W-1:0] rand_tile();
        logic [TILE_W-1:0] t;
        for (int i = 0; i < TILE_W / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic push_tile(input logic [TILE_W-1:0] t);
        fifo_q.push_back(t);
        sb_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: each pop must deliver the oldest pushed tile, rows 7..0, then a done and a count step
    always @(negedge clk) begin
        if (!rstn) begin
            inflight_valid = 1'b0;
            rows_seen      = 0;
            exp_count      = 0;
            prev_rd        = 1'b0;
        end else begin
            if (wl_if.row_valid) begin
                chk("row_without_tile", 64'(inflight_valid), 64'd1);
                chk("sb_row_idx", 64'(wl_if.row_idx), 64'(exp_ridx));
                chk("sb_row_data", wl_if.row_data, inflight[exp_ridx]);
                exp_ridx = exp_ridx - 3'd1;
                rows_seen++;
                if (rows_seen == 1) row_start_q.push_back(cyc);
            end
            if (load_done) begin
                chk("done_row_count", 64'(rows_seen), 64'(NR));
                exp_count++;
                chk("sb_tile_count", 64'(tile_count), 64'(exp_count & 16'hffff));
                done_q.push_back(cyc);
                inflight_valid = 1'b0;
                rows_seen      = 0;
            end
            if (wl_if.fifo_rd_en) begin
                chk("rd_pulse_width", 64'(prev_rd), 64'd0);
                chk("rd_while_empty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) inflight = sb_q.pop_front();
                inflight_valid = 1'b1;
                exp_ridx       = 3'(NR - 1);
                rows_seen      = 0;
            end
            prev_rd = wl_if.fifo_rd_en;
            if (abort) begin
                inflight_valid = 1'b0;
                rows_seen      = 0;
            end
        end
    end

    task automatic run_table();
        for (int k = 0; k < 12; k++) begin
            start = tbl[k].start;
            abort = tbl[k].abort;
            tick();
            chk($sformatf("tbl%0d_rd_en", k), 64'(wl_if.fifo_rd_en), 64'(tbl[k].exp_rd));
            chk($sformatf("tbl%0d_row_valid", k), 64'(wl_if.row_valid), 64'(tbl[k].exp_rv));
            chk($sformatf("tbl%0d_row_idx", k), 64'(wl_if.row_idx), 64'(tbl[k].exp_idx));
            chk($sformatf("tbl%0d_load_done", k), 64'(load_done), 64'(tbl[k].exp_done));
            chk($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].exp_busy));
            if (tbl[k].exp_rv) chk($sformatf("tbl%0d_row_data", k), wl_if.row_data, pat_row(int'(tbl[k].exp_idx)));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_rv(input string name, input int max);
        int i = 0;
        while (!wl_if.row_valid && i < max) begin
            tick();
            i++;
        end
        chk(name, 64'(wl_if.row_valid), 64'd1);
    endtask

    task automatic wait_done(input string name, input int max);
        int i = 0;
        while (!load_done && i < max) begin
            tick();
            i++;
        end
        chk(name, 64'(load_done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int b_done;
        int b_rows;
        int i;
        bit seen5;

        // Single-load cycle table: inputs before edge k, outputs after edge k
        for (int k = 0; k < 12; k++) begin
            tbl[k].start    = (k == 0);
            tbl[k].abort    = 1'b0;
            tbl[k].exp_rd   = (k == 0);
            tbl[k].exp_rv   = (k >= 2 && k <= 9);
            tbl[k].exp_idx  = (k >= 2 && k <= 9) ? 3'(9 - k) : 3'd0;
            tbl[k].exp_done = (k == 10);
            tbl[k].exp_busy = (k <= 10);
        end

        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) tick();
        chk("rst_rd_en", 64'(wl_if.fifo_rd_en), 64'd0);
        chk("rst_row_valid", 64'(wl_if.row_valid), 64'd0);
        chk("rst_row_idx", 64'(wl_if.row_idx), 64'd0);
        chk("rst_row_data", wl_if.row_data, 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tile_count", 64'(tile_count), 64'd0);
        rstn = 1'b1;
        tick();

        // Single load from a preloaded pattern tile
        push_tile(pat_tile());
        tick();
        run_table();
        chk("single_tile_count", 64'(tile_count), 64'd1);

        // Empty wait: request held without reading until a tile arrives
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            chk("empty_no_rd", 64'(wl_if.fifo_rd_en), 64'd0);
            chk("empty_not_busy", 64'(busy), 64'd0);
            tick();
        end
        push_tile(rand_tile());
        tick();
        chk("empty_rd_after_fill", 64'(wl_if.fifo_rd_en), 64'd1);
        wait_done("empty_done", 20);
        tick();
        chk("empty_tile_count", 64'(tile_count), 64'd2);

        // Queued request: two starts during LOAD give one extra load, a later start gives a third
        b_done = done_q.size();
        b_rows = row_start_q.size();
        for (int k = 0; k < 3; k++) push_tile(rand_tile());
        pulse_start();
        wait_rv("q_first_rows", 10);
        pulse_start();
        tick();
        pulse_start();
        i = 0;
        while (done_q.size() < b_done + 1 && i < 20) begin tick(); i++; end
        tick();
        wait_rv("q_second_rows", 10);
        pulse_start();
        i = 0;
        while (done_q.size() < b_done + 3 && i < 60) begin tick(); i++; end
        repeat (15) tick();
        chk("q_load_count", 64'(done_q.size() - b_done), 64'd3);
        if (row_start_q.size() >= b_rows + 2)
            chk("q_row_spacing", 64'(row_start_q[b_rows+1] - row_start_q[b_rows]), 64'd12);
        else
            chk("q_row_starts", 64'(row_start_q.size() - b_rows), 64'd2);
        chk("q_tile_count", 64'(tile_count), 64'd5);
        chk("q_fifo_drained", 64'(fifo_q.size()), 64'd0);

        // Abort at row_idx 4
        push_tile(rand_tile());
        push_tile(rand_tile());
        pulse_start();
        i = 0;
        seen5 = 1'b0;
        while (!seen5 && i < 15) begin
            if (wl_if.row_valid && wl_if.row_idx == 3'd5) seen5 = 1'b1;
            else begin tick(); i++; end
        end
        chk("abort_reach_row5", 64'(seen5), 64'd1);
        tick();
        chk("abort_at_row4", 64'(wl_if.row_idx), 64'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_row_valid", 64'(wl_if.row_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(load_done), 64'd0);
        chk("abort_tile_count", 64'(tile_count), 64'd5);
        chk("abort_fifo_level", 64'(fifo_q.size()), 64'd1);
        repeat (3) tick();
        chk("abort_still_no_done", 64'(load_done), 64'd0);
        pulse_start();
        wait_done("abort_next_done", 20);
        chk("abort_next_count", 64'(tile_count), 64'd6);
        tick();

        // Asynchronous reset in the middle of a load
        push_tile(pat_tile());
        pulse_start();
        wait_rv("arst_rows", 10);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_rd_en", 64'(wl_if.fifo_rd_en), 64'd0);
        chk("arst_row_valid", 64'(wl_if.row_valid), 64'd0);
        chk("arst_row_idx", 64'(wl_if.row_idx), 64'd0);
        chk("arst_row_data", wl_if.row_data, 64'd0);
        chk("arst_load_done", 64'(load_done), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_tile_count", 64'(tile_count), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        push_tile(pat_tile());
        tick();
        run_table();
        chk("arst_reload_count", 64'(tile_count), 64'd1);

        // abort and start together in IDLE with a pending request: nothing loads
        pulse_start();
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        push_tile(rand_tile());
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("as_no_rd", 64'(wl_if.fifo_rd_en), 64'd0);
            chk("as_not_busy", 64'(busy), 64'd0);
        end
        chk("as_tile_count", 64'(tile_count), 64'd1);

        // Randomized traffic checked by the scoreboard
        b_done = done_q.size();
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 63) == 0);
            if (fifo_q.size() < 3 && $urandom_range(0, 9) == 0) push_tile(rand_tile());
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (40) tick();
        chk("rnd_idle", 64'(busy), 64'd0);
        chk("rnd_tile_count", 64'(tile_count), 64'(exp_count & 16'hffff));
        chk("rnd_fifo_sync", 64'(sb_q.size()), 64'(fifo_q.size()));
        chk("rnd_loads_seen", 64'(done_q.size() > b_done + 20), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
